// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pattern generator (Fibonacci or Galois form)
// with seed load, step enable, all-zero lockup flag and period-wrap detection.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN. When defined, a zero seed or
// a zero state is replaced by DEFAULT_SEED and lockup is held low.
// WIDTH must lie in 3..32, DEFAULT_SEED must be nonzero, and in Galois form
// TAPS bit 0 must be set.
module lfsr_gen #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hD008),
    parameter bit               GALOIS       = 1'b0,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(16'h3C28)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             valid,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period
);

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] step_nx;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] seed_eff;

    // Fibonacci form: parity of the tapped bits shifts in at the LSB.
    function automatic logic [WIDTH-1:0] fib_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // Galois form: shift left and fold the tap mask in when the MSB falls out.
    function automatic logic [WIDTH-1:0] galois_next(input logic [WIDTH-1:0] s);
        return (s << 1) ^ (s[WIDTH-1] ? TAPS : '0);
    endfunction

    assign step_nx  = GALOIS ? galois_next(state_q) : fib_next(state_q);
    assign cnt_inc  = cnt_q + 1'b1;
    // With recovery enabled a zero seed would only lock up, so substitute the default.
    assign seed_eff = (RECOVER && (seed == '0)) ? DEFAULT_SEED : seed;

    // Next-state selection: load beats enable; idle cycles hold everything but wrap.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        lockup_d = lockup_q;
        wrap_d   = 1'b0;
        if (load) begin
            state_d  = seed_eff;
            start_d  = seed_eff;
            cnt_d    = '0;
            valid_d  = 1'b1;
            lockup_d = RECOVER ? 1'b0 : (seed_eff == '0);
        end else if (enable) begin
            valid_d = 1'b1;
            if (RECOVER && (state_q == '0)) begin
                // Escape the all-zero fixed point by reseeding.
                state_d = DEFAULT_SEED;
                cnt_d   = '0;
            end else begin
                state_d = step_nx;
                if (step_nx == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_inc;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            lockup_d = RECOVER ? 1'b0 : (state_d == '0);
        end
    end

    // State registers; asynchronous active-low reset returns to the default seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DEFAULT_SEED;
            start_q  <= DEFAULT_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign state    = state_q;
    assign bit_out  = state_q[WIDTH-1];
    assign valid    = valid_q;
    assign lockup   = lockup_q;
    assign wrap     = wrap_q;
    assign step_cnt = cnt_q;
    assign period   = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a 16-bit Fibonacci instance with default
// parameters and an 8-bit Galois instance (TAPS 8'h1D).
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ld16, en16, bo16, vl16, lk16, wr16;
    logic [15:0] sd16, st16, cn16, pd16;
    logic        ld8, en8, bo8, vl8, lk8, wr8;
    logic [7:0]  sd8, st8, cn8, pd8;

    lfsr_gen u16 (
        .clk(clk), .reset(reset), .load(ld16), .seed(sd16), .enable(en16),
        .state(st16), .bit_out(bo16), .valid(vl16), .lockup(lk16), .wrap(wr16),
        .step_cnt(cn16), .period(pd16)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .GALOIS(1'b1), .DEFAULT_SEED(8'h28)) u8 (
        .clk(clk), .reset(reset), .load(ld8), .seed(sd8), .enable(en8),
        .state(st8), .bit_out(bo8), .valid(vl8), .lockup(lk8), .wrap(wr8),
        .step_cnt(cn8), .period(pd8)
    );

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    typedef struct {
        int          d;
        logic [31:0] st, cnt, per;
        logic        vld, lk, wr;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    int          W[2]  = '{16, 8};
    logic [31:0] TP[2] = '{32'hD008, 32'h1D};
    bit          GL[2] = '{1'b0, 1'b1};
    logic [31:0] DS[2] = '{32'h3C28, 32'h28};

    logic [31:0] m_st[2], m_start[2], m_cnt[2], m_per[2];
    logic        m_vld[2], m_lk[2], m_wr[2];

    function automatic logic [31:0] msk(int d);
        return (32'h1 << W[d]) - 32'h1;
    endfunction

    function automatic logic [31:0] mstep(int d, logic [31:0] s);
        logic [31:0] r;
        logic        fb;
        if (GL[d]) begin
            r = s << 1;
            if (s[W[d]-1]) r = r ^ TP[d];
        end else begin
            fb = 1'b0;
            for (int i = 0; i < W[d]; i++)
                if (TP[d][i]) fb = fb ^ s[i];
            r = (s << 1) | {31'b0, fb};
        end
        return r & msk(d);
    endfunction

    task automatic model_reset(int d);
        m_st[d] = DS[d]; m_start[d] = DS[d]; m_cnt[d] = 0; m_per[d] = 0;
        m_vld[d] = 1'b0; m_lk[d] = 1'b0; m_wr[d] = 1'b0;
    endtask

    task automatic model_apply(int d, logic ld, logic [31:0] sd, logic en);
        logic [31:0] nx, s;
        m_wr[d] = 1'b0;
        if (ld) begin
            s = sd & msk(d);
            if (REC && s == 0) s = DS[d];
            m_st[d] = s; m_start[d] = s; m_cnt[d] = 0; m_vld[d] = 1'b1;
            m_lk[d] = !REC && (s == 0);
        end else if (en) begin
            m_vld[d] = 1'b1;
            if (REC && m_st[d] == 0) begin
                m_st[d] = DS[d]; m_cnt[d] = 0;
            end else begin
                nx = mstep(d, m_st[d]);
                m_cnt[d] = (m_cnt[d] + 1) & msk(d);
                if (nx == m_start[d]) begin
                    m_wr[d] = 1'b1; m_per[d] = m_cnt[d]; m_cnt[d] = 0;
                end
                m_st[d] = nx;
            end
            m_lk[d] = !REC && (m_st[d] == 0);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe(int d, output logic [31:0] st, cnt, per,
                           output logic vld, lk, wr, bo);
        if (d == 0) begin
            st = {16'b0, st16}; cnt = {16'b0, cn16}; per = {16'b0, pd16};
            vld = vl16; lk = lk16; wr = wr16; bo = bo16;
        end else begin
            st = {24'b0, st8}; cnt = {24'b0, cn8}; per = {24'b0, pd8};
            vld = vl8; lk = lk8; wr = wr8; bo = bo8;
        end
    endtask

    task automatic sb_compare(int d);
        exp_t        e;
        logic [31:0] st, cnt, per;
        logic        vld, lk, wr, bo;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            observe(d, st, cnt, per, vld, lk, wr, bo);
            chk($sformatf("d%0d_id", d), d, e.d);
            chk($sformatf("d%0d_state", d), st, e.st);
            chk($sformatf("d%0d_cnt", d), cnt, e.cnt);
            chk($sformatf("d%0d_period", d), per, e.per);
            chk($sformatf("d%0d_valid", d), {31'b0, vld}, {31'b0, e.vld});
            chk($sformatf("d%0d_lockup", d), {31'b0, lk}, {31'b0, e.lk});
            chk($sformatf("d%0d_wrap", d), {31'b0, wr}, {31'b0, e.wr});
            chk($sformatf("d%0d_bit_out", d), {31'b0, bo}, {31'b0, e.st[W[d]-1]});
        end
    endtask

    // Drive one cycle on instance d, queue the model result, compare after the edge.
    task automatic step(int d, logic ld, logic [31:0] sd, logic en);
        exp_t e;
        if (d == 0) begin ld16 = ld; sd16 = sd[15:0]; en16 = en; end
        else        begin ld8  = ld; sd8  = sd[7:0];  en8  = en; end
        model_apply(d, ld, sd, en);
        e.d = d; e.st = m_st[d]; e.cnt = m_cnt[d]; e.per = m_per[d];
        e.vld = m_vld[d]; e.lk = m_lk[d]; e.wr = m_wr[d];
        sb.push_back(e);
        @(posedge clk);
        #1;
        ld16 = 1'b0; en16 = 1'b0; ld8 = 1'b0; en8 = 1'b0;
        sb_compare(d);
    endtask

    int wcount, wstep;

    initial begin
        reset = 1'b0;
        ld16 = 1'b0; en16 = 1'b0; sd16 = '0;
        ld8  = 1'b0; en8  = 1'b0; sd8  = '0;
        model_reset(0); model_reset(1);
        #12;
        // Reset values
        chk("rst_state16", {16'b0, st16}, 32'h3C28);
        chk("rst_valid16", {31'b0, vl16}, 0);
        chk("rst_cnt16", {16'b0, cn16}, 0);
        chk("rst_period16", {16'b0, pd16}, 0);
        chk("rst_wrap16", {31'b0, wr16}, 0);
        chk("rst_lockup16", {31'b0, lk16}, 0);
        chk("rst_state8", {24'b0, st8}, 32'h28);
        reset = 1'b1;

        // Idle after reset: nothing moves
        for (int i = 0; i < 3; i++) step(0, 1'b0, 0, 1'b0);
        chk("idle_state", {16'b0, st16}, 32'h3C28);

        // Fibonacci reference sequence from 0x3C28
        step(0, 1'b1, 32'h3C28, 1'b0);
        step(0, 1'b0, 0, 1'b1);
        chk("fib1_state", {16'b0, st16}, 32'h7850);
        chk("fib1_cnt", {16'b0, cn16}, 1);
        chk("fib1_bit", {31'b0, bo16}, 0);
        step(0, 1'b0, 0, 1'b1);
        chk("fib2_state", {16'b0, st16}, 32'hF0A0);
        chk("fib2_cnt", {16'b0, cn16}, 2);
        chk("fib2_bit", {31'b0, bo16}, 1);
        step(0, 1'b0, 0, 1'b1);
        chk("fib3_state", {16'b0, st16}, 32'hE141);
        chk("fib3_cnt", {16'b0, cn16}, 3);
        chk("fib3_bit", {31'b0, bo16}, 1);

        // Full maximal period from 0x0001
        step(0, 1'b1, 32'h0001, 1'b0);
        wcount = 0; wstep = 0;
        for (int i = 1; i <= 65535; i++) begin
            step(0, 1'b0, 0, 1'b1);
            if (wr16) begin wcount++; wstep = i; end
        end
        chk("p16_wraps", wcount, 1);
        chk("p16_wrap_step", wstep, 65535);
        chk("p16_state", {16'b0, st16}, 32'h0001);
        chk("p16_period", {16'b0, pd16}, 32'hFFFF);
        chk("p16_cnt", {16'b0, cn16}, 0);

        // Load has priority over enable
        for (int i = 0; i < 5; i++) step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 32'hACE1, 1'b1);
        chk("ldpri_state", {16'b0, st16}, 32'hACE1);
        chk("ldpri_cnt", {16'b0, cn16}, 0);
        step(0, 1'b0, 0, 1'b1);
        chk("ldpri_next", {16'b0, st16}, 32'h59C3);

        // Zero seed
        step(0, 1'b1, 32'h0000, 1'b0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("zero_state", {16'b0, st16}, 32'h3C28);
        chk("zero_lockup", {31'b0, lk16}, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 0, 1'b1);
        chk("zero_lockup_run", {31'b0, lk16}, 0);
`else
        chk("zero_state", {16'b0, st16}, 0);
        chk("zero_lockup", {31'b0, lk16}, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0, 0, 1'b1);
            chk("lock_state", {16'b0, st16}, 0);
            chk("lock_wrap", {31'b0, wr16}, 1);
            chk("lock_period", {16'b0, pd16}, 1);
        end
        step(0, 1'b0, 0, 1'b0);
        chk("lock_idle_wrap", {31'b0, wr16}, 0);
`endif

        // Galois 8-bit full period
        step(1, 1'b1, 32'h01, 1'b0);
        wcount = 0; wstep = 0;
        for (int i = 1; i <= 255; i++) begin
            step(1, 1'b0, 0, 1'b1);
            if (wr8) begin wcount++; wstep = i; end
        end
        chk("p8_wraps", wcount, 1);
        chk("p8_wrap_step", wstep, 255);
        chk("p8_period", {24'b0, pd8}, 32'hFF);
        chk("p8_state", {24'b0, st8}, 32'h01);

        // Asynchronous reset between edges while stepping
        en8 = 1'b1;
        #3;
        reset = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        chk("arst_state8", {24'b0, st8}, 32'h28);
        chk("arst_valid8", {31'b0, vl8}, 0);
        chk("arst_period8", {24'b0, pd8}, 0);
        chk("arst_cnt8", {24'b0, cn8}, 0);
        chk("arst_state16", {16'b0, st16}, 32'h3C28);
        chk("arst_valid16", {31'b0, vl16}, 0);
        en8 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1, 1'b0, 0, 1'b1);
        chk("post_rst_step8", {24'b0, st8}, 32'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised successor to the fixed 16-bit seed/shift LFSR. Supports any width, a programmable tap mask, and Fibonacci or Galois structure. Adds a load/enable step control, all-zero lockup detection, and period-wrap detection with a step counter. Sits in the pattern/stimulus generation path, feeding test-vector and scrambler logic that consumes one pseudo-random word per enabled cycle.

Parameters:
WIDTH, 16, state width in bits; legal range 3..32.
TAPS, 16'hD008, feedback mask with WIDTH bits; bit i set means state[i] participates (default x^16+x^15+x^13+x^4+1).
GALOIS, 0, 0 = Fibonacci structure, 1 = Galois structure.
DEFAULT_SEED, 16'h3C28, state value loaded at reset; must be nonzero.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load  input  1  load seed this cycle; has priority over enable
seed  input  WIDTH  seed value, sampled when load=1
enable  input  1  advance one LFSR step this cycle
state  output  WIDTH  current LFSR register
bit_out  output  1  serial output, combinational state[WIDTH-1]
valid  output  1  state holds a loaded or stepped value
lockup  output  1  state is all-zero (stuck)
wrap  output  1  one-cycle pulse when state returns to its start value
step_cnt  output  WIDTH  steps since last load or wrap
period  output  WIDTH  step_cnt value captured at the most recent wrap

Behaviour:
- Reset (reset=0, asynchronous): state=DEFAULT_SEED, start register=DEFAULT_SEED, valid=0, lockup=0, wrap=0, step_cnt=0, period=0.
- All outputs except bit_out are registered. Latency is one clock from load/enable to the new state.
- Fibonacci step: fb = XOR-reduce(state & TAPS); state_next = {state[WIDTH-2:0], fb}.
- Galois step: msb = state[WIDTH-1]; state_next = (state << 1) ^ (msb ? TAPS : 0), truncated to WIDTH bits. TAPS bit 0 must be set.
- load=1, regardless of enable: state=seed, start=seed, step_cnt=0, wrap=0, valid=1, lockup=(seed==0).
- load=0 and enable=1: state=state_next, step_cnt+=1 (wraps modulo 2^WIDTH), valid=1.
  - If state_next==start: wrap=1 for that one cycle, period=step_cnt+1, step_cnt=0.
- load=0 and enable=0: all registers hold; wrap=0.
- Lockup: when state==0, the all-zero state is a fixed point. lockup=1 and steps keep state=0. Under this condition the wrap compare fires on every enabled step with period=1.
- Enable before any load after reset steps from DEFAULT_SEED.
- Reset asserted mid-run overrides everything in the same instant; the first post-reset edge behaves per the rules above.

Optional Feature:
Macro LFSR_LOCKUP_RECOVER_EN.
- Defined: a load of seed==0 loads DEFAULT_SEED instead, and start=DEFAULT_SEED. If the state ever becomes 0 (for example from a nonmaximal TAPS), the next enabled step forces state=DEFAULT_SEED and step_cnt=0. lockup is tied to 0.
- Undefined: behaviour is exactly as in Behaviour; the zero state is kept and flagged.

Test Plan:
1. Reset then release; no load; enable=0 for 3 cycles -> state=0x3C28, valid=0, step_cnt=0, wrap=0 throughout.
2. load seed=0x3C28, then enable for 3 cycles, Fibonacci default -> state sequence 0x7850, 0xF0A0, 0xE141; step_cnt 1, 2, 3; bit_out follows state[15] (0, 1, 1).
3. load seed=0x0001, enable for 65535 cycles -> wrap pulses exactly once, on step 65535. At that point state=0x0001, period=0xFFFF, step_cnt=0. No wrap at any earlier step.
4. Assert load (seed=0xACE1) and enable together mid-run -> state=0xACE1, step_cnt=0, no step taken. Next enabled cycle matches the reference model step of 0xACE1.
5. load seed=0x0000 -> without macro: lockup=1, state stays 0, wrap pulses on each enable with period=1. With LFSR_LOCKUP_RECOVER_EN: state=0x3C28, lockup=0.
6. GALOIS=1, WIDTH=8, TAPS=8'h1D: load 0x01 and run 255 steps -> period=255 with one wrap. Then assert reset low mid-step -> state immediately becomes DEFAULT_SEED[7:0] and valid=0.
